// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, LSB-first payload, optional parity and stop bit,
// one bit per baud clock; TX_OUT and busy come straight from flops.
module uart_tx_core #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  // state | meaning: IDLE line high | START bit 0 | DATA payload | PARITY | STOP line high
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  bit_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    case (state_q)
      S_IDLE: begin
        if (Data_Valid) begin
          data_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          cnt_d     = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: begin
        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          state_d = par_en_q ? S_PARITY : S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PARITY: state_d = S_STOP;
      S_STOP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered line is
  // already showing the bit belonging to the state being entered.
  always_comb begin
    bit_sel = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (cnt_d == CW'(i)) bit_sel = data_d[i];
    end
  end

  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b0;
    case (state_d)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
      S_START: begin
        tx_d   = 1'b0;
        busy_d = 1'b1;
      end
      S_DATA: begin
        tx_d   = bit_sel;
        busy_d = 1'b1;
      end
      S_PARITY: begin
        tx_d   = (^data_d) ^ par_typ_d;
        busy_d = 1'b1;
      end
      S_STOP: begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
      end
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: table vectors, hand sequences and randomized frames
// against a bit-list reference model of the UART frame.
module tb_uart_tx_core;

  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          TX_OUT;
  logic          busy;

  int errors = 0;
  int checks = 0;

  uart_tx_core #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          pe;
    logic          pt;
    int            exp_len;
    logic          exp_par;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Drives a strobe, then follows the frame until busy drops; returns at the
  // falling edge inside the first idle cycle with Data_Valid still as driven.
  task automatic send_check(input logic [DW-1:0] d, input logic pe, input logic pt,
                            input bit churn, input bit keep_valid,
                            output int len, output logic par_obs);
    bit exp_bits[$];
    int ones;
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Data_Valid = 1'b1;
    @(posedge clk);
    #1;
    Data_Valid = keep_valid;
    ones = 0;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) begin
      exp_bits.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (pe) exp_bits.push_back(((ones % 2) == 1) ^ pt);
    exp_bits.push_back(1'b1);
    len     = 0;
    par_obs = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (churn) begin
        P_DATA     = DW'($urandom);
        PAR_TYP    = 1'($urandom);
        PAR_EN     = 1'($urandom);
        Data_Valid = keep_valid | 1'($urandom);
      end
      @(negedge clk);
      if (!busy) break;
      if (len < exp_bits.size()) chk($sformatf("tx_bit%0d", len), int'(TX_OUT), int'(exp_bits[len]));
      else chk("frame_overrun", int'(busy), 0);
      if (pe && len == DW + 1) par_obs = TX_OUT;
      len++;
      @(posedge clk);
      #1;
    end
    chk("frame_len", len, exp_bits.size());
    chk("idle_tx", int'(TX_OUT), 1);
  endtask

  vec_t vecs[8];
  int   len;
  logic par;

  initial begin
    vecs[0] = '{d: 8'hA5, pe: 1'b0, pt: 1'b0, exp_len: 10, exp_par: 1'b0};
    vecs[1] = '{d: 8'h03, pe: 1'b1, pt: 1'b0, exp_len: 11, exp_par: 1'b0};
    vecs[2] = '{d: 8'h03, pe: 1'b1, pt: 1'b1, exp_len: 11, exp_par: 1'b1};
    vecs[3] = '{d: 8'hFF, pe: 1'b1, pt: 1'b0, exp_len: 11, exp_par: 1'b0};
    vecs[4] = '{d: 8'h01, pe: 1'b1, pt: 1'b1, exp_len: 11, exp_par: 1'b0};
    vecs[5] = '{d: 8'h00, pe: 1'b1, pt: 1'b1, exp_len: 11, exp_par: 1'b1};
    vecs[6] = '{d: 8'h80, pe: 1'b1, pt: 1'b0, exp_len: 11, exp_par: 1'b1};
    vecs[7] = '{d: 8'h7F, pe: 1'b1, pt: 1'b1, exp_len: 11, exp_par: 1'b0};

    rst        = 1'b0;
    P_DATA     = '0;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", int'(TX_OUT), 1);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_rst_idle_tx", int'(TX_OUT), 1);
      chk("post_rst_idle_busy", int'(busy), 0);
    end

    // Table vectors: the A5 entry also covers the 0,1,0,1,0,0,1,0,1,1 sequence.
    for (int v = 0; v < 8; v++) begin
      send_check(vecs[v].d, vecs[v].pe, vecs[v].pt, 1'b0, 1'b0, len, par);
      Data_Valid = 1'b0;
      chk($sformatf("vec%0d_len", v), len, vecs[v].exp_len);
      if (vecs[v].pe) chk($sformatf("vec%0d_par", v), int'(par), int'(vecs[v].exp_par));
      @(negedge clk);
    end

    // Back-to-back with Data_Valid held: second word set in the idle cycle.
    send_check(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, len, par);
    chk("b2b_idle_busy", int'(busy), 0);
    send_check(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, len, par);
    Data_Valid = 1'b0;
    @(negedge clk);

    // Input churn during a parity frame.
    send_check(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, len, par);
    Data_Valid = 1'b0;
    chk("churn_par", int'(par), 1);
    @(negedge clk);

    // Mid-frame reset during data bit 4.
    P_DATA     = 8'hFF;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Data_Valid = 1'b1;
    @(posedge clk);
    #1;
    Data_Valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("pre_rst_busy", int'(busy), 1);
    rst = 1'b0;
    #1;
    chk("async_rst_tx", int'(TX_OUT), 1);
    chk("async_rst_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("after_rst_busy", int'(busy), 0);
    send_check(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, len, par);
    Data_Valid = 1'b0;

    // Randomized frames against the reference model.
    for (int r = 0; r < 40; r++) begin
      send_check(DW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, len, par);
      Data_Valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
